// File: rtl/pong_game_core.sv
// Frame-stepped Pong engine: paddle/ball kinematics, collisions, scoring and match FSM.
// Every output is a register; motion advances only on frame_tick.
module pong_game_core #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PADDLE_H     = 72,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_STEP  = 3,
    parameter int BALL_STEP    = 2,
    parameter int SCORE_W      = 8,
    parameter int WIN_SCORE    = 7,
    parameter int TWO_PLAYER   = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [1:0]         up,
    input  logic [1:0]         down,
    output logic [9:0]         paddle0_y,
    output logic [9:0]         paddle1_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [2:0]         state,
    output logic [1:0]         winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // 11-bit signed so a step past the top or left edge shows up as negative.
    typedef logic signed [10:0] pos_t;

    localparam pos_t ZERO       = '0;
    localparam pos_t X_CENTRE   = pos_t'((H_RES - BALL_SIZE) / 2);
    localparam pos_t Y_CENTRE   = pos_t'((V_RES - BALL_SIZE) / 2);
    localparam pos_t X_MAX      = pos_t'(H_RES - BALL_SIZE);
    localparam pos_t Y_MAX      = pos_t'(V_RES - BALL_SIZE);
    localparam pos_t PAD_MAX    = pos_t'(V_RES - PADDLE_H);
    localparam pos_t PAD_CENTRE = pos_t'((V_RES - PADDLE_H) / 2);
    localparam pos_t LEFT_FACE  = pos_t'(16);
    localparam pos_t RIGHT_FACE = pos_t'(H_RES - 16 - BALL_SIZE);
    localparam pos_t PAD_SPAN   = pos_t'(PADDLE_H - 1);
    localparam pos_t BALL_SPAN  = pos_t'(BALL_SIZE - 1);
    localparam pos_t B_STEP     = pos_t'(BALL_STEP);
    localparam pos_t P_STEP     = pos_t'(PADDLE_STEP);

    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]         pad0_q, pad0_d, pad1_q, pad1_d;
    logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d;
    logic [1:0]         winner_q, winner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q;
    pos_t               nx, ny;
    logic               hit_l, hit_r;

    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic u, input logic d);
        pos_t t;
        t = $signed({1'b0, y});
        if (u && !d)
            t = t - P_STEP;
        else if (d && !u)
            t = t + P_STEP;
        if (t < ZERO)
            t = ZERO;
        else if (t > PAD_MAX)
            t = PAD_MAX;
        return t[9:0];
    endfunction

    function automatic logic overlaps(input pos_t by, input logic [9:0] py);
        pos_t p;
        p = $signed({1'b0, py});
        return (by <= p + PAD_SPAN) && (by + BALL_SPAN >= p);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        pad0_d   = pad0_q;
        pad1_d   = pad1_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        score0_d = score0_q;
        score1_d = score1_q;
        winner_d = winner_q;
        cnt_d    = cnt_q;
        nx       = $signed({1'b0, ball_x_q}) + (dx_neg_q ? -B_STEP : B_STEP);
        ny       = $signed({1'b0, ball_y_q}) + (dy_neg_q ? -B_STEP : B_STEP);
        hit_l    = 1'b0;
        hit_r    = 1'b0;

        if (frame_tick && (state_q == S_SERVE || state_q == S_PLAY)) begin
            pad0_d = paddle_next(pad0_q, up[0], down[0]);
            pad1_d = paddle_next(pad1_q, up[1], down[1]);
        end

        case (state_q)
            S_IDLE: begin
                ball_x_d = X_CENTRE[9:0];
                ball_y_d = Y_CENTRE[9:0];
                if (start) begin
                    state_d  = S_SERVE;
                    score0_d = '0;
                    score1_d = '0;
                    winner_d = 2'b00;
                    cnt_d    = '0;
                end
            end
            S_SERVE: begin
                ball_x_d = X_CENTRE[9:0];
                ball_y_d = Y_CENTRE[9:0];
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (ny < ZERO) begin
                        ny       = ZERO;
                        dy_neg_d = 1'b0;
                    end else if (ny > Y_MAX) begin
                        ny       = Y_MAX;
                        dy_neg_d = 1'b1;
                    end
                    ball_y_d = ny[9:0];
                    // Collisions see the registered paddles, i.e. before this frame's move.
                    hit_l = dx_neg_q && (nx <= LEFT_FACE) && overlaps(ny, pad0_q);
                    hit_r = !dx_neg_q && (nx >= RIGHT_FACE) &&
                            ((TWO_PLAYER == 0) || overlaps(ny, pad1_q));
                    if (hit_l) begin
                        ball_x_d = LEFT_FACE[9:0];
                        dx_neg_d = 1'b0;
                        if (TWO_PLAYER == 0)
                            score0_d = sat_inc(score0_q);
                    end else if (hit_r) begin
                        ball_x_d = RIGHT_FACE[9:0];
                        dx_neg_d = 1'b1;
                    end else if (nx <= ZERO) begin
                        ball_x_d = '0;
                        cnt_d    = '0;
                        if (TWO_PLAYER != 0) begin
                            score1_d = sat_inc(score1_q);
                            dx_neg_d = 1'b1;
                            state_d  = S_POINT;
                        end else begin
                            winner_d = 2'b00;
                            state_d  = S_OVER;
                        end
                    end else if (nx >= X_MAX) begin
                        ball_x_d = X_MAX[9:0];
                        cnt_d    = '0;
                        score0_d = sat_inc(score0_q);
                        dx_neg_d = 1'b0;
                        state_d  = S_POINT;
                    end else begin
                        ball_x_d = nx[9:0];
                    end
                end
            end
            S_POINT: begin
                if (int'(score0_q) == WIN_SCORE) begin
                    winner_d = 2'b01;
                    state_d  = S_OVER;
                end else if (int'(score1_q) == WIN_SCORE) begin
                    winner_d = 2'b10;
                    state_d  = S_OVER;
                end else if (frame_tick) begin
                    if (cnt_q == CNT_W'(POINT_FRAMES - 1)) begin
                        state_d = S_SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (start && !start_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ball_x_q <= X_CENTRE[9:0];
            ball_y_q <= Y_CENTRE[9:0];
            pad0_q   <= PAD_CENTRE[9:0];
            pad1_q   <= PAD_CENTRE[9:0];
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b1;
            score0_q <= '0;
            score1_q <= '0;
            winner_q <= 2'b00;
            cnt_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            pad0_q   <= pad0_d;
            pad1_q   <= pad1_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
            start_q  <= start;
        end
    end

    assign paddle0_y = pad0_q;
    assign paddle1_y = pad1_q;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign score0    = score0_q;
    assign score1    = score1_q;
    assign state     = state_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core: a default two-player core plus a
// single-player core with a full-height paddle and 2-bit score for saturation.
module tb_pong_game_core;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start, start_b;
    logic [1:0] up, down;

    logic [9:0] paddle0_y, paddle1_y, ball_x, ball_y;
    logic [7:0] score0, score1;
    logic [2:0] state;
    logic [1:0] winner;

    logic [9:0] b_paddle0_y, b_paddle1_y, b_ball_x, b_ball_y;
    logic [1:0] b_score0, b_score1;
    logic [2:0] b_state;
    logic [1:0] b_winner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pong_game_core dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .up(up), .down(down),
        .paddle0_y(paddle0_y), .paddle1_y(paddle1_y), .ball_x(ball_x), .ball_y(ball_y),
        .score0(score0), .score1(score1), .state(state), .winner(winner)
    );

    pong_game_core #(.TWO_PLAYER(0), .SCORE_W(2), .PADDLE_H(480)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start_b),
        .up(up), .down(down),
        .paddle0_y(b_paddle0_y), .paddle1_y(b_paddle1_y), .ball_x(b_ball_x), .ball_y(b_ball_y),
        .score0(b_score0), .score1(b_score1), .state(b_state), .winner(b_winner)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change on negedge; each call leaves the bench just after a negedge.
    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},  state, 0);
        check({tag, "_ball_x"}, ball_x, 316);
        check({tag, "_ball_y"}, ball_y, 236);
        check({tag, "_pad0"},   paddle0_y, 204);
        check({tag, "_pad1"},   paddle1_y, 204);
        check({tag, "_score0"}, score0, 0);
        check({tag, "_score1"}, score1, 0);
        check({tag, "_winner"}, winner, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; start_b = 1'b0; up = 2'b00; down = 2'b00;
        cycles(2);
        reset = 1'b0;
        check_idle("reset");
        check("b_reset_state", b_state, 0);

        // Serve countdown and first ball step
        start = 1'b1; cycles(1); start = 1'b0;
        check("serve_entry", state, 1);
        ticks(59);  check("serve_59", state, 1);
        ticks(1);   check("play_entry", state, 2);
        check("serve_held_x", ball_x, 316);
        ticks(1);
        check("step1_x", ball_x, 318);
        check("step1_y", ball_y, 234);

        // Paddle clamp at top, down move, both-pressed hold
        up = 2'b01; ticks(100); up = 2'b00;
        check("pad0_top_clamp", paddle0_y, 0);
        check("k101_x", ball_x, 518);
        check("k101_y", ball_y, 34);
        down = 2'b01; ticks(10);
        check("pad0_down", paddle0_y, 30);
        up = 2'b01; ticks(5); up = 2'b00; down = 2'b00;
        check("pad0_both_hold", paddle0_y, 30);
        check("pad1_untouched", paddle1_y, 204);

        // Right miss: left scores
        ticks(41);
        check("k157_state", state, 2);
        check("k157_x", ball_x, 630);
        ticks(1);
        check("rmiss_state", state, 3);
        check("rmiss_score0", score0, 1);
        check("rmiss_score1", score1, 0);
        check("rmiss_x", ball_x, 632);
        ticks(29); check("point_29", state, 3);
        ticks(1);  check("point_done", state, 1);

        // Further right misses up to the winning point
        for (int s = 2; s <= 7; s++) begin
            ticks(60);
            ticks(158);
            check($sformatf("rally%0d_state", s), state, 3);
            check($sformatf("rally%0d_score0", s), score0, s);
            if (s < 7) ticks(30);
        end
        cycles(1);
        check("over_state", state, 4);
        check("over_winner", winner, 1);
        ticks(5);
        check("over_frozen_x", ball_x, 632);
        check("over_hold", state, 4);
        start = 1'b1; cycles(1);
        check("over_to_idle", state, 0);
        start = 1'b0;

        // Right paddle hit, left miss, left paddle hit
        reset = 1'b1; cycles(1); reset = 1'b0;
        check("rst2_state", state, 0);
        check("rst2_score0", score0, 0);
        check("rst2_winner", winner, 0);
        start = 1'b1; up = 2'b11; cycles(1); start = 1'b0;
        ticks(60);
        check("b2_play", state, 2);
        check("b2_pad0", paddle0_y, 24);
        check("b2_pad1", paddle1_y, 24);
        ticks(150);
        check("rhit_x", ball_x, 616);
        check("rhit_y", ball_y, 62);
        check("rhit_pad1", paddle1_y, 0);
        ticks(1);
        check("rhit_back_x", ball_x, 614);
        check("rhit_back_y", ball_y, 64);
        up = 2'b00;
        ticks(307);
        check("lmiss_state", state, 3);
        check("lmiss_score1", score1, 1);
        check("lmiss_score0", score0, 0);
        check("lmiss_x", ball_x, 0);
        ticks(29); check("lmiss_point_29", state, 3);
        ticks(1);  check("lmiss_serve", state, 1);
        ticks(60); check("lserve_play", state, 2);
        ticks(149);
        check("lhit_pre_x", ball_x, 18);
        check("lhit_pre_y", ball_y, 60);
        ticks(1);
        check("lhit_x", ball_x, 16);
        check("lhit_y", ball_y, 62);
        ticks(1);
        check("lhit_out_x", ball_x, 18);
        check("lhit_out_y", ball_y, 64);
        check("lhit_no_score_2p", score0, 0);

        // Reset overriding a frame tick mid-play discards the score
        reset = 1'b1; frame_tick = 1'b1; cycles(1); frame_tick = 1'b0; reset = 1'b0;
        check_idle("rst_play");

        // Single-player wall mode with saturating hit counter
        start_b = 1'b1; cycles(1); start_b = 1'b0;
        check("sp_serve", b_state, 1);
        ticks(60);  check("sp_play", b_state, 2);
        ticks(450);
        check("sp_hit1_score", b_score0, 1);
        check("sp_hit1_x", b_ball_x, 16);
        ticks(600); check("sp_hit2_score", b_score0, 2);
        ticks(600); check("sp_hit3_score", b_score0, 3);
        ticks(600);
        check("sp_sat_score", b_score0, 3);
        check("sp_hit4_x", b_ball_x, 16);
        check("sp_still_play", b_state, 2);
        reset = 1'b1; frame_tick = 1'b1; cycles(1); frame_tick = 1'b0; reset = 1'b0;
        check("sp_rst_state", b_state, 0);
        check("sp_rst_x", b_ball_x, 316);
        check("sp_rst_y", b_ball_y, 236);
        check("sp_rst_score", b_score0, 0);
        check("sp_rst_pad0", b_paddle0_y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
